// File: rtl/mmio_io_controller_if.sv
// ----------------------------------------------------------------------------
// mmio_io_controller_if
// CPU-side I/O access bundle for mmio_io_controller.
//   io_req    : access valid this cycle
//   io_we     : 1 = write, 0 = read
//   io_sel    : target (0 switches, 1 LED, 2 tube, 3 status)
//   io_width  : bytes to read from the switches
//   io_sext   : sign-extend a narrow switch read
//   io_wdata  : write data
//   io_rdata  : read data, valid while io_ready=1, otherwise 0
//   io_ready  : access completes this cycle
//   cpu_stall : CPU must hold its request and stall
// The CPU drives through modport master; the controller uses modport slave.
// ----------------------------------------------------------------------------
interface mmio_io_controller_if;
  logic        io_req;
  logic        io_we;
  logic [1:0]  io_sel;
  logic [2:0]  io_width;
  logic        io_sext;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        cpu_stall;

  modport master (
    output io_req, io_we, io_sel, io_width, io_sext, io_wdata,
    input  io_rdata, io_ready, cpu_stall
  );

  modport slave (
    input  io_req, io_we, io_sel, io_width, io_sext, io_wdata,
    output io_rdata, io_ready, cpu_stall
  );
endinterface

// File: rtl/mmio_io_controller.sv
// ----------------------------------------------------------------------------
// mmio_io_controller
// Memory-mapped I/O sequencer between the CPU load/store path and board I/O.
// LED/tube/status accesses complete in the request cycle. A switch read
// stalls the CPU while the user enters one byte per debounced button press;
// the assembled value returns zero- or sign-extended in a single DONE cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : CPU access bundle (mmio_io_controller_if.slave)
//   sw_in        : raw switch levels (8)
//   btn_in       : raw confirm button
//   led_out      : LED register (16)
//   tube_value   : tube display register (32)
//   byte_idx     : index of the byte currently awaited
//   input_active : high while waiting for user input
// ----------------------------------------------------------------------------
module mmio_io_controller #(
  parameter int               CNT_W           = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mmio_io_controller_if.slave         bus,
  input  logic [7:0]                  sw_in,
  input  logic                        btn_in,
  output logic [15:0]                 led_out,
  output logic [31:0]                 tube_value,
  output logic [1:0]                  byte_idx,
  output logic                        input_active
);

  localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  // Map the requested byte count onto 1..4.
  function automatic logic [2:0] eff_width(input logic [2:0] w);
    logic [2:0] r;
    case (w)
      3'd0:                   r = 3'd1;
      3'd1, 3'd2, 3'd3, 3'd4: r = w;
      default:                r = 3'd4;
    endcase
    return r;
  endfunction

  // Zero- or sign-extend the assembled switch value from its byte width.
  function automatic logic [31:0] extend_read(input logic [31:0] raw,
                                              input logic [2:0]  width,
                                              input logic        sext);
    logic [31:0] r;
    case (width)
      3'd1:    r = {{24{sext & raw[7]}},  raw[7:0]};
      3'd2:    r = {{16{sext & raw[15]}}, raw[15:0]};
      3'd3:    r = {{8{sext & raw[23]}},  raw[23:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [7:0]       sw_meta_r, sw_sync_r;
  logic             btn_meta_r, btn_sync_r;
  logic             btn_db_r, btn_db_prev_r;
  logic [CNT_W-1:0] db_cnt_r;
  logic             press_s;
  logic [31:0]      buf_r;
  logic [2:0]       count_r;
  logic [2:0]       width_r;
  logic             sext_r;
  logic [15:0]      led_r;
  logic [31:0]      tube_r;

  logic             start_read_s, capture_s, wr_led_s, wr_tube_s;
  logic             io_ready_s, cpu_stall_s, input_active_s;
  logic [31:0]      io_rdata_s;

  // Two-flop synchronizers for the raw board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= 8'h00;
      sw_sync_r  <= 8'h00;
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      sw_meta_r  <= sw_in;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn_in;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Debounce: the synchronized level must differ for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r      <= {CNT_W{1'b0}};
      btn_db_r      <= 1'b0;
      btn_db_prev_r <= 1'b0;
    end else begin
      btn_db_prev_r <= btn_db_r;
      if (btn_sync_r != btn_db_r) begin
        if (db_cnt_r == DB_LAST) begin
          btn_db_r <= btn_sync_r;
          db_cnt_r <= {CNT_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + CNT_W'(1);
        end
      end else begin
        db_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign press_s = btn_db_r & ~btn_db_prev_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and combinational bus responses.
  always_comb begin
    state_nxt_s    = state_r;
    start_read_s   = 1'b0;
    capture_s      = 1'b0;
    wr_led_s       = 1'b0;
    wr_tube_s      = 1'b0;
    io_ready_s     = 1'b0;
    cpu_stall_s    = 1'b0;
    input_active_s = 1'b0;
    io_rdata_s     = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (bus.io_req) begin
          if (bus.io_we) begin
            io_ready_s = 1'b1;
            case (bus.io_sel)
              2'd1:    wr_led_s  = 1'b1;
              2'd2:    wr_tube_s = 1'b1;
              default: wr_led_s  = 1'b0;
            endcase
          end else if (bus.io_sel == 2'd0) begin
            cpu_stall_s  = 1'b1;
            start_read_s = 1'b1;
            // A button already held down must be released before byte 0.
            state_nxt_s  = btn_db_r ? WAIT_RELEASE : WAIT_PRESS;
          end else begin
            io_ready_s = 1'b1;
            case (bus.io_sel)
              2'd1:    io_rdata_s = {16'h0000, led_r};
              2'd2:    io_rdata_s = tube_r;
              default: io_rdata_s = {23'h000000, btn_db_r, sw_sync_r};
            endcase
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_PRESS: begin
        cpu_stall_s    = 1'b1;
        input_active_s = 1'b1;
        if (press_s) begin
          capture_s   = 1'b1;
          state_nxt_s = WAIT_RELEASE;
        end else begin
          state_nxt_s = WAIT_PRESS;
        end
      end
      WAIT_RELEASE: begin
        cpu_stall_s    = 1'b1;
        input_active_s = 1'b1;
        if (!btn_db_r) begin
          state_nxt_s = (count_r == width_r) ? DONE : WAIT_PRESS;
        end else begin
          state_nxt_s = WAIT_RELEASE;
        end
      end
      DONE: begin
        io_ready_s  = 1'b1;
        io_rdata_s  = extend_read(buf_r, width_r, sext_r);
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Switch-read datapath: byte buffer, byte counter, latched width/extension.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= 32'h0000_0000;
      count_r <= 3'd0;
      width_r <= 3'd1;
      sext_r  <= 1'b0;
    end else if (start_read_s) begin
      buf_r   <= 32'h0000_0000;
      count_r <= 3'd0;
      width_r <= eff_width(bus.io_width);
      sext_r  <= bus.io_sext;
    end else if (capture_s) begin
      buf_r[{count_r[1:0], 3'b000} +: 8] <= sw_sync_r;
      count_r <= count_r + 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // LED and tube output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r  <= 16'h0000;
      tube_r <= 32'h0000_0000;
    end else begin
      if (wr_led_s) begin
        led_r <= bus.io_wdata[15:0];
      end
      if (wr_tube_s) begin
        tube_r <= bus.io_wdata;
      end
    end
  end

  assign bus.io_ready  = io_ready_s;
  assign bus.io_rdata  = io_rdata_s;
  assign bus.cpu_stall = cpu_stall_s;
  assign led_out       = led_r;
  assign tube_value    = tube_r;
  assign byte_idx      = count_r[1:0];
  assign input_active  = input_active_s;

endmodule

// File: tb/tb_mmio_io_controller.sv
// ----------------------------------------------------------------------------
// tb_mmio_io_controller
// Directed bench for mmio_io_controller with a short debounce window.
// Single-cycle CPU accesses come from a vector table; switch reads, button
// bounce, held button and mid-read reset are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_mmio_io_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sw_in = 8'h00;
  logic        btn_in = 1'b0;
  logic [15:0] led_out;
  logic [31:0] tube_value;
  logic [1:0]  byte_idx;
  logic        input_active;

  int n_vec = 0;
  int n_err = 0;
  logic stall_ok;

  mmio_io_controller_if bus ();

  mmio_io_controller #(
    .CNT_W           (20),
    .DEBOUNCE_CYCLES (20'd4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sw_in        (sw_in),
    .btn_in       (btn_in),
    .led_out      (led_out),
    .tube_value   (tube_value),
    .byte_idx     (byte_idx),
    .input_active (input_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
    logic [31:0] exp_tube;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One single-cycle access: response checked mid-cycle, registers after the edge.
  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    bus.io_req   = v.req;
    bus.io_we    = v.we;
    bus.io_sel   = v.sel;
    bus.io_wdata = v.wdata;
    @(negedge clk);
    check("vec_ready", {31'h0, bus.io_ready}, {31'h0, v.exp_ready});
    check("vec_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("vec_rdata", bus.io_rdata, v.exp_rdata);
    @(posedge clk); #1;
    bus.io_req = 1'b0;
    check("vec_led", {16'h0, led_out}, {16'h0, v.exp_led});
    check("vec_tube", tube_value, v.exp_tube);
  endtask

  task automatic start_read(input logic [2:0] w, input logic s);
    @(posedge clk); #1;
    bus.io_req   = 1'b1;
    bus.io_we    = 1'b0;
    bus.io_sel   = 2'd0;
    bus.io_width = w;
    bus.io_sext  = s;
    #1;
    check("rd_stall_req_cycle", {31'h0, bus.cpu_stall}, 32'h1);
    check("rd_ready_req_cycle", {31'h0, bus.io_ready}, 32'h0);
    stall_ok = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) stall_ok = 1'b0;
    end
  endtask

  task automatic press_byte(input logic [1:0] idx, input logic [7:0] val, input logic last);
    logic got;
    @(negedge clk);
    check("press_byte_idx", {30'h0, byte_idx}, {30'h0, idx});
    check("press_input_active", {31'h0, input_active}, 32'h1);
    sw_in  = val;
    btn_in = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) stall_ok = 1'b0;
      if (byte_idx != idx) got = 1'b1;
    end
    check("press_captured", {31'h0, got}, 32'h1);
    btn_in = 1'b0;
    if (!last) wait_cycles(10);
  endtask

  task automatic finish_read(input logic [31:0] exp);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (bus.io_ready) got = 1'b1;
      else if (!bus.cpu_stall) stall_ok = 1'b0;
    end
    check("done_seen", {31'h0, got}, 32'h1);
    check("done_rdata", bus.io_rdata, exp);
    check("done_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("stall_throughout", {31'h0, stall_ok}, 32'h1);
    @(posedge clk); #1;
    bus.io_req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'h0, bus.io_ready}, 32'h0);
    check("rdata_zero_idle", bus.io_rdata, 32'h0);
  endtask

  initial begin
    bus.io_req   = 1'b0;
    bus.io_we    = 1'b0;
    bus.io_sel   = 2'd0;
    bus.io_width = 3'd0;
    bus.io_sext  = 1'b0;
    bus.io_wdata = 32'h0;
    stall_ok     = 1'b1;

    //            req   we    sel   wdata          rdy   rdata          led       tube
    vecs[0] = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 1'b0, 32'h0000_0000, 16'h0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 2'd1, 32'h1234_ABCD, 1'b1, 32'h0000_0000, 16'hABCD, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 1'b1, 32'h0000_ABCD, 16'hABCD, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 16'hABCD, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 16'hABCD, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 16'hABCD, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b1, 2'd3, 32'h5555_5555, 1'b1, 32'h0000_0000, 16'hABCD, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0000, 1'b1, 32'h0000_00A5, 16'hABCD, 32'hDEAD_BEEF};
    vecs[8] = '{1'b1, 1'b1, 2'd1, 32'hFFFF_0001, 1'b1, 32'h0000_0000, 16'h0001, 32'hDEAD_BEEF};
    vecs[9] = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 1'b1, 32'h0000_0001, 16'h0001, 32'hDEAD_BEEF};

    // Reset state.
    #2;
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_tube", tube_value, 32'h0);
    check("rst_ready", {31'h0, bus.io_ready}, 32'h0);
    check("rst_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("rst_active", {31'h0, input_active}, 32'h0);
    check("rst_byte_idx", {30'h0, byte_idx}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sw_in = 8'hA5;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Two-byte read, zero-extended.
    start_read(3'd2, 1'b0);
    press_byte(2'd0, 8'h34, 1'b0);
    press_byte(2'd1, 8'h92, 1'b1);
    finish_read(32'h0000_9234);

    // Two-byte read, sign-extended.
    start_read(3'd2, 1'b1);
    press_byte(2'd0, 8'h34, 1'b0);
    press_byte(2'd1, 8'h92, 1'b1);
    finish_read(32'hFFFF_9234);

    // Width 0 behaves as one byte.
    start_read(3'd0, 1'b1);
    press_byte(2'd0, 8'h7F, 1'b1);
    finish_read(32'h0000_007F);

    // Bouncing button captures nothing; a stable press captures exactly once.
    start_read(3'd1, 1'b1);
    sw_in = 8'h80;
    for (int t = 0; t < 10; t++) begin
      btn_in = ~btn_in;
      wait_cycles(2);
    end
    btn_in = 1'b0;
    wait_cycles(10);
    check("bounce_no_capture", {30'h0, byte_idx}, 32'h0);
    check("bounce_still_waiting", {31'h0, input_active}, 32'h1);
    press_byte(2'd0, 8'h80, 1'b1);
    finish_read(32'hFFFF_FF80);

    // Button held at read start; width 7 clamps to 4 presses.
    btn_in = 1'b1;
    sw_in  = 8'h99;
    repeat (12) @(negedge clk);
    start_read(3'd7, 1'b1);
    wait_cycles(15);
    check("held_no_capture", {30'h0, byte_idx}, 32'h0);
    check("held_waiting", {31'h0, input_active}, 32'h1);
    btn_in = 1'b0;
    wait_cycles(10);
    press_byte(2'd0, 8'h11, 1'b0);
    press_byte(2'd1, 8'h22, 1'b0);
    press_byte(2'd2, 8'h33, 1'b0);
    press_byte(2'd3, 8'hC4, 1'b1);
    finish_read(32'hC433_2211);

    // Reset in the middle of a read.
    start_read(3'd2, 1'b0);
    press_byte(2'd0, 8'h5A, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_active", {31'h0, input_active}, 32'h1);
    rst_n      = 1'b0;
    bus.io_req = 1'b0;
    #1;
    check("midrst_led", {16'h0, led_out}, 32'h0);
    check("midrst_tube", tube_value, 32'h0);
    check("midrst_stall", {31'h0, bus.cpu_stall}, 32'h0);
    check("midrst_active", {31'h0, input_active}, 32'h0);
    check("midrst_byte_idx", {30'h0, byte_idx}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", {31'h0, input_active}, 32'h0);
    apply_vec('{1'b1, 1'b0, 2'd1, 32'h0, 1'b1, 32'h0, 16'h0000, 32'h0});
    apply_vec('{1'b1, 1'b0, 2'd2, 32'h0, 1'b1, 32'h0, 16'h0000, 32'h0});

    // A fresh read after reset starts clean at byte 0.
    start_read(3'd1, 1'b0);
    press_byte(2'd0, 8'h05, 1'b1);
    finish_read(32'h0000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_io_controller.md
Name: mmio_io_controller

Overview:
- Memory-mapped I/O sequencer between the CPU load/store path and the board I/O (8 switches, one confirm button, 16 LEDs, 7-segment tube value).
- Serves CPU I/O accesses. Zero-latency accesses complete in the request cycle.
- A switch-input read stalls the CPU. The user enters the value one byte per debounced button press, and the result returns zero- or sign-extended.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000: cycles the synchronized button must hold a new level before the debounced level changes.
- CNT_W, 20: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- io_req, input, 1: CPU I/O access valid this cycle.
- io_we, input, 1: 1 = write, 0 = read.
- io_sel, input, 2: target. 0 = switch input, 1 = LED, 2 = tube, 3 = status.
- io_width, input, 3: bytes to read from the switches.
- io_sext, input, 1: sign-extend a switch read narrower than 4 bytes.
- io_wdata, input, 32: write data.
- io_rdata, output, 32: read data, valid while io_ready=1.
- io_ready, output, 1: access completes this cycle.
- cpu_stall, output, 1: CPU must hold its request and stall.
- sw_in, input, 8: raw switch levels.
- btn_in, input, 1: raw confirm button.
- led_out, output, 16: LED register.
- tube_value, output, 32: tube display register.
- byte_idx, output, 2: index of the byte currently awaited, for user feedback.
- input_active, output, 1: high while waiting for user input.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; led_out, tube_value, io_rdata buffer, byte count and byte_idx all cleared to 0.
  - Synchronizer flops, debounced level and debounce counter cleared to 0.
  - Combinational outputs evaluate to io_ready=0, cpu_stall=0, input_active=0.
  - Reset mid-read abandons the read; no partial data survives.
- Input conditioning:
  - sw_in and btn_in each pass through a 2-flop synchronizer.
  - Debounce: when the synchronized button differs from btn_db, the counter increments; otherwise it clears. When the counter reaches DEBOUNCE_CYCLES-1, btn_db takes the new level and the counter clears.
  - press = btn_db rising edge, a single-cycle pulse.
- Effective width: io_width=0 is treated as 1; io_width>4 is clamped to 4. Width is latched at the start of a read.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
- IDLE, write (io_req && io_we):
  - sel 1: led_out <= io_wdata[15:0].
  - sel 2: tube_value <= io_wdata.
  - sel 0 or 3: write ignored.
  - io_ready=1 in the same cycle; no stall.
- IDLE, read with sel 1/2/3: io_ready=1 in the same cycle, no stall. io_rdata returns:
  - sel 1: {16'b0, led_out}.
  - sel 2: tube_value.
  - sel 3: {23'b0, btn_db, sync_sw}.
- IDLE, read with sel 0:
  - cpu_stall=1 combinationally in that same cycle.
  - Next edge: buffer<=0, count<=0, width and sext latched, state<=WAIT_PRESS.
  - If btn_db=1 at entry, the state goes to WAIT_RELEASE instead, so a held button cannot supply byte 0.
- WAIT_PRESS:
  - cpu_stall=1, input_active=1, byte_idx=count.
  - On press: buffer[count*8 +: 8] <= sync_sw, count increments, state<=WAIT_RELEASE.
- WAIT_RELEASE:
  - cpu_stall=1, input_active=1.
  - When btn_db=0: state<=DONE if count==width, else WAIT_PRESS.
- DONE (exactly one cycle):
  - cpu_stall=0, io_ready=1.
  - io_rdata = buffer, byte 0 in bits [7:0] (little-endian).
  - If sext and width<4, bits above 8*width copy bit 8*width-1; otherwise they are 0.
  - Next state IDLE. A new io_req in the DONE cycle is ignored; the CPU presents its next access from IDLE.
- Requests arriving in WAIT_PRESS/WAIT_RELEASE are ignored; the CPU is stalled.
- io_rdata is 0 whenever io_ready=0.
- Latency of a switch read = 1 + user time + debounce delays + 1 (DONE cycle).

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: assert rst_n=0 mid-WAIT_PRESS -> immediately led_out=0, tube_value=0, cpu_stall=0; after release, state is IDLE.
- Write sel1 with io_wdata=32'h1234ABCD -> io_ready=1 in the same cycle, led_out=16'hABCD next edge. Then read sel1 -> io_rdata=32'h0000ABCD.
- Read sel0, width=2, sext=0; switches 8'h34 press/release, then 8'h92 press/release -> cpu_stall high throughout, byte_idx 0 then 1, a single DONE cycle with io_rdata=32'h00009234.
- Same 2-byte entry with sext=1 -> io_rdata=32'hFFFF9234. width=0 with one byte 8'h7F -> 32'h0000007F.
- Button bounce: toggle btn_in every 2 cycles for 20 cycles during WAIT_PRESS -> no byte captured. Then hold the button stable -> exactly one capture.
- Button already held when the sel0 read starts -> no capture until release and a new press. Width 7 requires exactly 4 presses.
